// File: rtl/vend_sequencer_pkg.sv
// Shared types, constants and helpers for the vend_sequencer coin/drink controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        DISPENSE,
        CHANGE
    } vend_state_t;

    localparam int CREDIT_W       = 8;
    localparam int COIN_100_UNITS = 1;
    localparam int COIN_500_UNITS = 5;

    localparam int DEF_PRICE_D1 = 3;
    localparam int DEF_PRICE_D2 = 5;
    localparam int DEF_PRICE_D3 = 7;
    localparam int DEF_PRICE_D4 = 10;

    // Default price table indexed by drink number (0 = drink 1).
    function automatic int price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return DEF_PRICE_D1;
            2'd1:    return DEF_PRICE_D2;
            2'd2:    return DEF_PRICE_D3;
            default: return DEF_PRICE_D4;
        endcase
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        case (v)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Handshake/coin bus between the vending controller and its surroundings.
// disp_fault exists only when VEND_DISP_TIMEOUT_EN is defined.
interface vend_sequencer_if;
    logic       m100;
    logic       m500;
    logic [3:0] drink_sel;
    logic       cancel;
    logic       dispenser_ready;
    logic       dispense_req;
    logic [1:0] drink_id;
    logic       coin_out_100;
    logic       coin_out_500;
    logic       coin_reject;
    logic       insufficient;
    logic [7:0] credit;
    logic       busy;
`ifdef VEND_DISP_TIMEOUT_EN
    logic       disp_fault;
`endif

    modport master (
        output m100, m500, drink_sel, cancel, dispenser_ready,
        input  dispense_req, drink_id, coin_out_100, coin_out_500,
               coin_reject, insufficient, credit, busy
`ifdef VEND_DISP_TIMEOUT_EN
        , input disp_fault
`endif
    );

    modport slave (
        input  m100, m500, drink_sel, cancel, dispenser_ready,
        output dispense_req, drink_id, coin_out_100, coin_out_500,
               coin_reject, insufficient, credit, busy
`ifdef VEND_DISP_TIMEOUT_EN
        , output disp_fault
`endif
    );
endinterface

// File: rtl/vend_sequencer_change_emitter.sv
// Pays out a credit balance as 500/100 coin pulses separated by COIN_GAP idle cycles.
// The first pulse is registered on the same edge that start is sampled.
module change_emitter
    import vend_pkg::*;
#(
    parameter int COIN_GAP = 2,
    parameter int W        = CREDIT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_credit,
    output logic         o_coin_100,
    output logic         o_coin_500,
    output logic [W-1:0] o_remain_next,
    output logic         o_done
);
    localparam int GAP_W = (COIN_GAP < 1) ? 1 : $clog2(COIN_GAP + 1);

    logic [GAP_W-1:0] r_gap;
    logic [W-1:0]     r_remain;
    logic             r_active;
    logic             r_coin_100;
    logic             r_coin_500;

    logic [W-1:0]     w_src;
    logic             w_emit;
    logic             w_is500;
    logic [W-1:0]     w_remain_d;

    // Choose the next coin and the balance left after it.
    always_comb begin
        w_src      = i_start ? i_credit : r_remain;
        w_emit     = i_start || (r_active && (r_gap == '0) && (r_remain != '0));
        w_is500    = (w_src >= W'(COIN_500_UNITS));
        w_remain_d = r_remain;
        if (w_emit) begin
            w_remain_d = w_is500 ? (w_src - W'(COIN_500_UNITS))
                                 : (w_src - W'(COIN_100_UNITS));
        end
    end

    // Pulse, balance and gap registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap      <= '0;
            r_remain   <= '0;
            r_active   <= 1'b0;
            r_coin_100 <= 1'b0;
            r_coin_500 <= 1'b0;
        end else begin
            r_coin_100 <= w_emit && !w_is500;
            r_coin_500 <= w_emit && w_is500;
            r_remain   <= w_remain_d;
            if (w_emit) begin
                r_gap <= GAP_W'(COIN_GAP);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end
            if (i_start) begin
                r_active <= 1'b1;
            end else if (o_done) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_coin_100    = r_coin_100;
    assign o_coin_500    = r_coin_500;
    assign o_remain_next = w_remain_d;
    assign o_done        = r_active && (r_remain == '0);
endmodule

// File: rtl/vend_sequencer.sv
// Coffee-machine control FSM: coin credit, drink selection, dispenser handshake
// and change payout. Define VEND_DISP_TIMEOUT_EN to add the dispenser timeout
// (DISP_TIMEOUT parameter and disp_fault output).
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE_D1   = price_of(2'd0),
    parameter int PRICE_D2   = price_of(2'd1),
    parameter int PRICE_D3   = price_of(2'd2),
    parameter int PRICE_D4   = price_of(2'd3),
    parameter int MAX_CREDIT = 50,
    parameter int COIN_GAP   = 2
`ifdef VEND_DISP_TIMEOUT_EN
    ,
    parameter int DISP_TIMEOUT = 1000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    vend_sequencer_if.slave  vif
);
    localparam int SUM_W = CREDIT_W + 1;

    vend_state_t         r_state;
    vend_state_t         w_state_d;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_d;
    logic                r_req;
    logic                w_req_d;
    logic [1:0]          r_drink_id;
    logic [1:0]          w_drink_id_d;
    logic                r_reject;
    logic                w_reject_d;
    logic                r_insuff;
    logic                w_insuff_d;
    logic                r_busy;
    logic                w_busy_d;

    logic [SUM_W-1:0]    w_coin_units;
    logic [SUM_W-1:0]    w_sum;
    logic                w_over;
    logic [CREDIT_W-1:0] w_sat;
    logic                w_onehot;
    logic [1:0]          w_sel_idx;
    logic [CREDIT_W-1:0] w_sel_price;

    logic                w_start;
    logic [CREDIT_W-1:0] w_start_credit;
    logic [CREDIT_W-1:0] w_emit_remain_d;
    logic                w_emit_done;
    logic                w_coin_100;
    logic                w_coin_500;

`ifdef VEND_DISP_TIMEOUT_EN
    localparam int TMO_W = (DISP_TIMEOUT < 2) ? 1 : $clog2(DISP_TIMEOUT + 1);
    logic [CREDIT_W-1:0] r_price;
    logic [CREDIT_W-1:0] w_price_d;
    logic [TMO_W-1:0]    r_tmo;
    logic [TMO_W-1:0]    w_tmo_d;
    logic                r_fault;
    logic                w_fault_d;
    logic [SUM_W-1:0]    w_refund_sum;
    logic [CREDIT_W-1:0] w_refund;
`endif

    // Coin arithmetic with saturation, and selection decode.
    always_comb begin
        w_coin_units = (vif.m100 ? SUM_W'(COIN_100_UNITS) : '0)
                     + (vif.m500 ? SUM_W'(COIN_500_UNITS) : '0);
        w_sum        = {1'b0, r_credit} + w_coin_units;
        w_over       = (w_sum > SUM_W'(MAX_CREDIT));
        w_sat        = w_over ? CREDIT_W'(MAX_CREDIT) : w_sum[CREDIT_W-1:0];
        w_onehot     = is_onehot4(vif.drink_sel);
        w_sel_idx    = onehot_idx(vif.drink_sel);
        case (w_sel_idx)
            2'd0:    w_sel_price = CREDIT_W'(PRICE_D1);
            2'd1:    w_sel_price = CREDIT_W'(PRICE_D2);
            2'd2:    w_sel_price = CREDIT_W'(PRICE_D3);
            default: w_sel_price = CREDIT_W'(PRICE_D4);
        endcase
`ifdef VEND_DISP_TIMEOUT_EN
        w_refund_sum = {1'b0, r_credit} + {1'b0, r_price};
        w_refund     = (w_refund_sum > SUM_W'(MAX_CREDIT)) ? CREDIT_W'(MAX_CREDIT)
                                                           : w_refund_sum[CREDIT_W-1:0];
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_d      = r_state;
        w_credit_d     = r_credit;
        w_req_d        = r_req;
        w_drink_id_d   = r_drink_id;
        w_reject_d     = 1'b0;
        w_insuff_d     = 1'b0;
        w_start        = 1'b0;
        w_start_credit = '0;
`ifdef VEND_DISP_TIMEOUT_EN
        w_price_d      = r_price;
        w_tmo_d        = '0;
        w_fault_d      = 1'b0;
`endif
        case (r_state)
            IDLE, CREDIT: begin
                w_credit_d = w_sat;
                w_reject_d = w_over;
                if (w_onehot && (r_credit >= w_sel_price)) begin
                    // Price checked against pre-coin credit; same-cycle coins still count.
                    w_credit_d   = w_sat - w_sel_price;
                    w_drink_id_d = w_sel_idx;
                    w_req_d      = 1'b1;
                    w_state_d    = DISPENSE;
`ifdef VEND_DISP_TIMEOUT_EN
                    w_price_d    = w_sel_price;
`endif
                end else if (w_onehot) begin
                    w_insuff_d = 1'b1;
                    if (w_sat != '0) w_state_d = CREDIT;
                end else if (vif.cancel && (r_state == CREDIT)) begin
                    w_start        = 1'b1;
                    w_start_credit = w_sat;
                    w_credit_d     = w_emit_remain_d;
                    w_state_d      = CHANGE;
                end else if (w_sat != '0) begin
                    w_state_d = CREDIT;
                end
            end
            DISPENSE: begin
                w_reject_d = vif.m100 || vif.m500;
                if (r_req && vif.dispenser_ready) begin
                    w_req_d = 1'b0;
                    if (r_credit != '0) begin
                        w_start        = 1'b1;
                        w_start_credit = r_credit;
                        w_credit_d     = w_emit_remain_d;
                        w_state_d      = CHANGE;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
`ifdef VEND_DISP_TIMEOUT_EN
                else if (r_tmo == TMO_W'(DISP_TIMEOUT - 1)) begin
                    w_req_d        = 1'b0;
                    w_fault_d      = 1'b1;
                    w_start        = 1'b1;
                    w_start_credit = w_refund;
                    w_credit_d     = w_emit_remain_d;
                    w_state_d      = CHANGE;
                end else begin
                    w_tmo_d = r_tmo + TMO_W'(1);
                end
`endif
            end
            CHANGE: begin
                w_reject_d = vif.m100 || vif.m500;
                w_credit_d = w_emit_remain_d;
                if (w_emit_done) w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
        w_busy_d = (w_state_d == DISPENSE) || (w_state_d == CHANGE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_credit   <= '0;
            r_req      <= 1'b0;
            r_drink_id <= '0;
            r_reject   <= 1'b0;
            r_insuff   <= 1'b0;
            r_busy     <= 1'b0;
`ifdef VEND_DISP_TIMEOUT_EN
            r_price    <= '0;
            r_tmo      <= '0;
            r_fault    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_credit   <= w_credit_d;
            r_req      <= w_req_d;
            r_drink_id <= w_drink_id_d;
            r_reject   <= w_reject_d;
            r_insuff   <= w_insuff_d;
            r_busy     <= w_busy_d;
`ifdef VEND_DISP_TIMEOUT_EN
            r_price    <= w_price_d;
            r_tmo      <= w_tmo_d;
            r_fault    <= w_fault_d;
`endif
        end
    end

    change_emitter #(
        .COIN_GAP (COIN_GAP),
        .W        (CREDIT_W)
    ) u_change (
        .clk           (clk),
        .rst           (rst),
        .i_start       (w_start),
        .i_credit      (w_start_credit),
        .o_coin_100    (w_coin_100),
        .o_coin_500    (w_coin_500),
        .o_remain_next (w_emit_remain_d),
        .o_done        (w_emit_done)
    );

    assign vif.dispense_req = r_req;
    assign vif.drink_id     = r_drink_id;
    assign vif.coin_out_100 = w_coin_100;
    assign vif.coin_out_500 = w_coin_500;
    assign vif.coin_reject  = r_reject;
    assign vif.insufficient = r_insuff;
    assign vif.credit       = r_credit;
    assign vif.busy         = r_busy;
`ifdef VEND_DISP_TIMEOUT_EN
    assign vif.disp_fault   = r_fault;
`endif
endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer; the timeout scenario runs when
// VEND_DISP_TIMEOUT_EN is defined.
module tb_vend_sequencer;
    import vend_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    vend_sequencer_if vif ();

`ifdef VEND_DISP_TIMEOUT_EN
    vend_sequencer #(.COIN_GAP(2), .MAX_CREDIT(50), .DISP_TIMEOUT(8)) dut (
`else
    vend_sequencer #(.COIN_GAP(2), .MAX_CREDIT(50)) dut (
`endif
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic a100, input logic a500, input logic [3:0] sel, input logic can);
        vif.m100 = a100; vif.m500 = a500; vif.drink_sel = sel; vif.cancel = can;
        cyc();
        vif.m100 = 1'b0; vif.m500 = 1'b0; vif.drink_sel = 4'd0; vif.cancel = 1'b0;
    endtask

    // Observe a payout from the current cycle (t = 0) until busy drops.
    task automatic run_change(output logic [63:0] p100, output logic [63:0] p500, output int idle_t);
        p100 = '0; p500 = '0; idle_t = -1;
        for (int t = 0; t < 60; t++) begin
            if (vif.coin_out_100) p100[t] = 1'b1;
            if (vif.coin_out_500) p500[t] = 1'b1;
            if (!vif.busy) begin idle_t = t; break; end
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (vif.credit !== 8'd0) begin $display("FAIL reset_credit: got %0d expected 0", vif.credit); errors++; end
        checks++; if ({vif.dispense_req, vif.coin_out_100, vif.coin_out_500, vif.coin_reject, vif.insufficient, vif.busy} !== 6'd0)
            begin $display("FAIL reset_outputs: got %b expected 000000", {vif.dispense_req, vif.coin_out_100, vif.coin_out_500, vif.coin_reject, vif.insufficient, vif.busy}); errors++; end
        checks++; if (vif.drink_id !== 2'd0) begin $display("FAIL reset_drink_id: got %0d expected 0", vif.drink_id); errors++; end
        rst = 1'b0;
        cyc();
        checks++; if (dut.r_state !== IDLE) begin $display("FAIL reset_state: got %0d expected %0d", dut.r_state, IDLE); errors++; end
    endtask

    task automatic test_purchase();
        logic [63:0] p100, p500;
        int idle_t;
        pulse(1'b0, 1'b1, 4'd0, 1'b0);
        checks++; if (dut.r_state !== CREDIT) begin $display("FAIL purchase_to_credit: got %0d expected %0d", dut.r_state, CREDIT); errors++; end
        pulse(1'b1, 1'b0, 4'd0, 1'b0);
        checks++; if (vif.credit !== 8'd6) begin $display("FAIL purchase_credit6: got %0d expected 6", vif.credit); errors++; end
        pulse(1'b0, 1'b0, 4'b0001, 1'b0);
        checks++; if ({vif.dispense_req, vif.busy} !== 2'b11) begin $display("FAIL purchase_req: got %b expected 11", {vif.dispense_req, vif.busy}); errors++; end
        checks++; if (vif.drink_id !== 2'd0) begin $display("FAIL purchase_drink_id: got %0d expected 0", vif.drink_id); errors++; end
        checks++; if (vif.credit !== 8'd3) begin $display("FAIL purchase_credit3: got %0d expected 3", vif.credit); errors++; end
        repeat (4) cyc();
        checks++; if (vif.dispense_req !== 1'b1) begin $display("FAIL purchase_req_held: got %b expected 1", vif.dispense_req); errors++; end
        vif.dispenser_ready = 1'b1;
        cyc();
        vif.dispenser_ready = 1'b0;
        checks++; if (vif.dispense_req !== 1'b0) begin $display("FAIL purchase_req_drop: got %b expected 0", vif.dispense_req); errors++; end
        run_change(p100, p500, idle_t);
        checks++; if (p100 !== 64'h49) begin $display("FAIL purchase_p100: got %h expected 49", p100); errors++; end
        checks++; if (p500 !== 64'h0) begin $display("FAIL purchase_p500: got %h expected 0", p500); errors++; end
        checks++; if (idle_t !== 7) begin $display("FAIL purchase_idle_t: got %0d expected 7", idle_t); errors++; end
        checks++; if (vif.credit !== 8'd0) begin $display("FAIL purchase_final_credit: got %0d expected 0", vif.credit); errors++; end
    endtask

    task automatic test_insufficient();
        logic [63:0] p100, p500;
        int idle_t;
        repeat (4) pulse(1'b1, 1'b0, 4'd0, 1'b0);
        pulse(1'b0, 1'b0, 4'b0010, 1'b0);
        checks++; if (vif.insufficient !== 1'b1) begin $display("FAIL insuff_pulse: got %b expected 1", vif.insufficient); errors++; end
        checks++; if (vif.credit !== 8'd4) begin $display("FAIL insuff_credit: got %0d expected 4", vif.credit); errors++; end
        checks++; if (dut.r_state !== CREDIT) begin $display("FAIL insuff_state: got %0d expected %0d", dut.r_state, CREDIT); errors++; end
        cyc();
        checks++; if ({vif.insufficient, vif.dispense_req} !== 2'b00) begin $display("FAIL insuff_one_cycle: got %b expected 00", {vif.insufficient, vif.dispense_req}); errors++; end
        pulse(1'b0, 1'b0, 4'd0, 1'b1);
        run_change(p100, p500, idle_t);
        checks++; if ({p500, p100} !== {64'h0, 64'h249} || idle_t !== 10)
            begin $display("FAIL insuff_refund: got p500=%h p100=%h idle=%0d expected p500=0 p100=249 idle=10", p500, p100, idle_t); errors++; end
    endtask

    task automatic test_both_coins_cancel();
        logic [63:0] p100, p500;
        int idle_t;
        pulse(1'b0, 1'b0, 4'd0, 1'b1);
        checks++; if ({vif.busy, vif.coin_out_100, vif.coin_out_500} !== 3'b000) begin $display("FAIL cancel_idle_noop: got %b expected 000", {vif.busy, vif.coin_out_100, vif.coin_out_500}); errors++; end
        pulse(1'b1, 1'b1, 4'd0, 1'b0);
        checks++; if (vif.credit !== 8'd6) begin $display("FAIL both_credit: got %0d expected 6", vif.credit); errors++; end
        checks++; if (vif.coin_reject !== 1'b0) begin $display("FAIL both_reject: got %b expected 0", vif.coin_reject); errors++; end
        pulse(1'b0, 1'b0, 4'd0, 1'b1);
        checks++; if (vif.credit !== 8'd1) begin $display("FAIL cancel_credit_after_500: got %0d expected 1", vif.credit); errors++; end
        run_change(p100, p500, idle_t);
        checks++; if (p500 !== 64'h1 || p100 !== 64'h8 || idle_t !== 4)
            begin $display("FAIL cancel_change: got p500=%h p100=%h idle=%0d expected p500=1 p100=8 idle=4", p500, p100, idle_t); errors++; end
    endtask

    task automatic test_saturation();
        logic [63:0] p100, p500;
        int idle_t;
        repeat (9) pulse(1'b0, 1'b1, 4'd0, 1'b0);
        repeat (3) pulse(1'b1, 1'b0, 4'd0, 1'b0);
        checks++; if (vif.credit !== 8'd48) begin $display("FAIL sat_credit48: got %0d expected 48", vif.credit); errors++; end
        pulse(1'b0, 1'b1, 4'd0, 1'b0);
        checks++; if (vif.credit !== 8'd50) begin $display("FAIL sat_credit50: got %0d expected 50", vif.credit); errors++; end
        checks++; if (vif.coin_reject !== 1'b1) begin $display("FAIL sat_reject: got %b expected 1", vif.coin_reject); errors++; end
        pulse(1'b0, 1'b0, 4'b1000, 1'b0);
        checks++; if (vif.credit !== 8'd40 || vif.drink_id !== 2'd3 || vif.coin_reject !== 1'b0)
            begin $display("FAIL sat_buy4: got credit=%0d id=%0d rej=%b expected credit=40 id=3 rej=0", vif.credit, vif.drink_id, vif.coin_reject); errors++; end
        pulse(1'b1, 1'b0, 4'd0, 1'b1);
        checks++; if (vif.coin_reject !== 1'b1 || vif.credit !== 8'd40 || vif.dispense_req !== 1'b1)
            begin $display("FAIL busy_reject: got rej=%b credit=%0d req=%b expected rej=1 credit=40 req=1", vif.coin_reject, vif.credit, vif.dispense_req); errors++; end
        vif.dispenser_ready = 1'b1;
        cyc();
        vif.dispenser_ready = 1'b0;
        run_change(p100, p500, idle_t);
        checks++; if (p500 !== 64'h249249 || p100 !== 64'h0 || idle_t !== 22)
            begin $display("FAIL sat_refund: got p500=%h p100=%h idle=%0d expected p500=249249 p100=0 idle=22", p500, p100, idle_t); errors++; end
    endtask

    task automatic test_multi_sel_reset();
        repeat (4) pulse(1'b0, 1'b1, 4'd0, 1'b0);
        pulse(1'b0, 1'b0, 4'b0110, 1'b0);
        checks++; if ({vif.insufficient, vif.dispense_req, vif.busy} !== 3'b000 || vif.credit !== 8'd20)
            begin $display("FAIL multi_sel_ignored: got flags=%b credit=%0d expected flags=000 credit=20", {vif.insufficient, vif.dispense_req, vif.busy}, vif.credit); errors++; end
        pulse(1'b0, 1'b0, 4'd0, 1'b1);
        checks++; if (vif.coin_out_500 !== 1'b1 || vif.credit !== 8'd15) begin $display("FAIL midgap_first: got c500=%b credit=%0d expected c500=1 credit=15", vif.coin_out_500, vif.credit); errors++; end
        cyc();
        rst = 1'b1;
        #1;
        checks++; if (vif.credit !== 8'd0 || vif.busy !== 1'b0 || dut.r_state !== IDLE)
            begin $display("FAIL async_reset: got credit=%0d busy=%b state=%0d expected credit=0 busy=0 state=%0d", vif.credit, vif.busy, dut.r_state, IDLE); errors++; end
        cyc();
        rst = 1'b0;
        repeat (4) cyc();
        checks++; if ({vif.coin_out_100, vif.coin_out_500, vif.busy} !== 3'b000 || vif.credit !== 8'd0)
            begin $display("FAIL after_reset_quiet: got flags=%b credit=%0d expected flags=000 credit=0", {vif.coin_out_100, vif.coin_out_500, vif.busy}, vif.credit); errors++; end
    endtask

`ifdef VEND_DISP_TIMEOUT_EN
    task automatic test_timeout();
        logic [63:0] p100, p500;
        int idle_t;
        repeat (2) pulse(1'b0, 1'b1, 4'd0, 1'b0);
        pulse(1'b0, 1'b0, 4'b1000, 1'b0);
        checks++; if (vif.credit !== 8'd0 || vif.dispense_req !== 1'b1) begin $display("FAIL tmo_start: got credit=%0d req=%b expected credit=0 req=1", vif.credit, vif.dispense_req); errors++; end
        repeat (7) cyc();
        checks++; if (vif.dispense_req !== 1'b1 || vif.disp_fault !== 1'b0) begin $display("FAIL tmo_early: got req=%b fault=%b expected req=1 fault=0", vif.dispense_req, vif.disp_fault); errors++; end
        cyc();
        checks++; if (vif.disp_fault !== 1'b1 || vif.dispense_req !== 1'b0 || vif.credit !== 8'd5)
            begin $display("FAIL tmo_fault: got fault=%b req=%b credit=%0d expected fault=1 req=0 credit=5", vif.disp_fault, vif.dispense_req, vif.credit); errors++; end
        run_change(p100, p500, idle_t);
        checks++; if (p500 !== 64'h9 || p100 !== 64'h0 || idle_t !== 4)
            begin $display("FAIL tmo_refund: got p500=%h p100=%h idle=%0d expected p500=9 p100=0 idle=4", p500, p100, idle_t); errors++; end
        checks++; if (vif.disp_fault !== 1'b0) begin $display("FAIL tmo_fault_once: got %b expected 0", vif.disp_fault); errors++; end
    endtask
`endif

    initial begin
        vif.m100 = 1'b0; vif.m500 = 1'b0; vif.drink_sel = 4'd0;
        vif.cancel = 1'b0; vif.dispenser_ready = 1'b0;
        rst = 1'b1;
        test_reset();
        test_purchase();
        test_insufficient();
        test_both_coins_cancel();
        test_saturation();
        test_multi_sel_reset();
`ifdef VEND_DISP_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
